ysyx_2022040010_if_bridge: RTL



---
 rtl/ysyx_2022040010_if_bridge_pkg.sv | 19 +
 rtl/ysyx_2022040010_if_line.sv | 45 ++++
 rtl/ysyx_2022040010_if_bridge.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ysyx_2022040010_if_bridge_pkg.sv
// Shared widths, the NOP encoding and the fetch FSM encoding for the IF bridge.
package ysyx_2022040010_if_bridge_pkg;

    localparam int INST_ADDR_W = 64;               // InstAddrBus 63:0
    localparam int INST_W      = 32;               // InstBus 31:0
    localparam int MEM_DATA_W  = 64;               // MemDataBus 63:0
    localparam int TAG_W       = INST_ADDR_W - 3;  // doubleword-aligned line tag

    // addi x0,x0,0 -- substituted for an instruction whose fetch failed
    localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ysyx_2022040010_if_line.sv
// One-doubleword instruction line buffer: valid bit, tag, data, tag compare
// and 32-bit word select.
module ysyx_2022040010_if_line
    import ysyx_2022040010_if_bridge_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fill_i,
    input  logic [TAG_W-1:0]       fill_tag_i,
    input  logic [MEM_DATA_W-1:0]  fill_data_i,
    input  logic                   inv_i,
    input  logic [INST_ADDR_W-1:2] addr_i,
    output logic                   hit_o,
    output logic [INST_W-1:0]      word_o
);

    logic                  valid_q;
    logic [TAG_W-1:0]      tag_q;
    logic [MEM_DATA_W-1:0] data_q;

    // Valid bit: cleared by reset or invalidate, set by a fill.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            valid_q <= 1'b0;
        end else if (inv_i) begin
            valid_q <= 1'b0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
        end
    end

    // Tag and data capture on fill.
    always_ff @(posedge clk) begin
        // NOTE: tag/data are deliberately not reset; valid_q alone qualifies them.
        if (fill_i && !inv_i) begin
            tag_q  <= fill_tag_i;
            data_q <= fill_data_i;
        end
    end

    assign hit_o  = valid_q && (tag_q == addr_i[INST_ADDR_W-1:3]);
    assign word_o = addr_i[2] ? data_q[63:32] : data_q[31:0];

endmodule

// File: rtl/ysyx_2022040010_if_bridge.sv
// Instruction-fetch bridge: serves 32-bit fetches from a one-line buffer and
// refills it over a valid/ready 64-bit bus, stalling the front end on a miss.
module ysyx_2022040010_if_bridge
    import ysyx_2022040010_if_bridge_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_ce_i,
    input  logic [63:0] inst_addr_i,
    input  logic        flush_i,
    output logic [31:0] inst_data_o,
    output logic        stall_o,
    output logic        fetch_err_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [63:0] mem_req_addr_o,
    input  logic        mem_resp_valid_i,
    input  logic [63:0] mem_resp_data_i,
    input  logic        mem_resp_err_i
);

    fetch_state_e      state_q, state_d;
    logic              drop_q, drop_d;
    logic [TAG_W-1:0]  req_tag_q, req_tag_d;

    logic              line_hit;
    logic [31:0]       line_word;
    logic              line_fill;

    logic              stall;
    logic              fetch_err;
    logic [31:0]       inst_data;
    logic              req_valid;

    // Fetches are word aligned; the byte offset bits carry no information.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^inst_addr_i[1:0];

    ysyx_2022040010_if_line u_line (
        .clk         (clk),
        .rst         (rst),
        .fill_i      (line_fill),
        .fill_tag_i  (req_tag_q),
        .fill_data_i (mem_resp_data_i),
        .inv_i       (flush_i),
        .addr_i      (inst_addr_i[63:2]),
        .hit_o       (line_hit),
        .word_o      (line_word)
    );

    // FSM state and response-drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // Request tag; only meaningful while a request is outstanding.
    always_ff @(posedge clk) begin
        req_tag_q <= req_tag_d;
    end

    // Next-state and fetch-side outputs.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_d   = state_q;
        drop_d    = drop_q;
        req_tag_d = req_tag_q;
        line_fill = 1'b0;
        stall     = 1'b0;
        fetch_err = 1'b0;
        inst_data = 32'h0;
        req_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (inst_ce_i) begin
                    if (line_hit) begin
                        inst_data = line_word;
                    end else begin
                        stall     = 1'b1;
                        req_tag_d = inst_addr_i[63:3];
                        state_d   = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                req_valid = 1'b1;
                stall     = inst_ce_i;
                if (flush_i) drop_d = 1'b1;
                if (mem_req_ready_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                stall = inst_ce_i;
                if (flush_i) drop_d = 1'b1;
                if (mem_resp_valid_i) begin
                    // A flush seen now or earlier discards the response entirely.
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                    if (!(drop_q || flush_i)) begin
                        if (mem_resp_err_i) begin
                            state_d = ST_ERR;
                        end else begin
                            line_fill = 1'b1;
                        end
                    end
                end
            end
            ST_ERR: begin
                inst_data = NOP_INST;
                fetch_err = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign stall_o         = !rst && stall;
    assign fetch_err_o     = !rst && fetch_err;
    assign inst_data_o     = rst ? 32'h0 : inst_data;
    assign mem_req_valid_o = !rst && req_valid;
    assign mem_req_addr_o  = rst ? 64'h0 : {req_tag_q, 3'b000};

endmodule
